microcode_sequencer: RTL and testbench
======================================

MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
 ROM_AW, 9, microcode ROM address width.
 RAM_AW, 6, data RAM address width.
 TIMES_W, 9, repeat-count field width.
 NLOOP, 2, number of hardware loops (1..4).
 CNT_W, 9, loop iteration counter width.
 LOOP_START, {9'd288,9'd21}, NLOOP*ROM_AW packed loop start addresses; loop k in slice k.
 LOOP_END, {9'd301,9'd116}, NLOOP*ROM_AW packed loop end addresses.
 LOOP_CNT, {9'd294,9'd294}, NLOOP*CNT_W packed backward-jump counts.
 CMD_ADD, 4, RAM address of the ADD constant word; CMD_SUB, 8, SUB constant word; CMD_CUBIC, 16, CUBIC constant word (each RAM_AW wide).
REQ-002 Ports (name, direction, width, meaning), one per line:
 clk, in, 1, single clock, all state updates on rising edge.
 reset, in, 1, asynchronous, active-high.
 start, in, 1, program launch request, sampled in IDLE only.
 rom_addr, out, ROM_AW, microcode address (registered).
 rom_q, in, 3*RAM_AW+2+TIMES_W, microcode word {dest, src1, op[1:0], times, src2}, MSB first.
 ram_a_addr, out, RAM_AW, port-A read address (combinational).
 ram_b_addr, out, RAM_AW, port-B address (combinational).
 ram_b_w, out, 1, port-B write enable (combinational).
 pe, out, 11, processing-element control vector (registered).
 busy, out, 1, high in every state except IDLE.
 done, out, 1, one-cycle completion pulse (registered).

Function
REQ-003 States: IDLE, FETCH, READ_SRC1, READ_SRC2, CALC, WAIT, WRITE, DON.
REQ-004 IDLE -> FETCH when start=1; start in any other state ignored. FETCH -> READ_SRC1 unconditionally (one ROM read latency).
REQ-005 READ_SRC1 -> READ_SRC2; READ_SRC2 -> DON if times==0, else CALC.
REQ-006 count (TIMES_W) loads times in READ_SRC1, decrements in CALC; CALC -> WAIT when count==1 (times=N gives N CALC cycles).
REQ-007 WAIT -> WRITE -> READ_SRC1; ram_b_w=1 only in WRITE.
REQ-008 DON: done<=1 for exactly one cycle, then IDLE; rom_addr<=0, all loop counters reload LOOP_CNT.
REQ-009 In WAIT, rom_addr update: lowest k with rom_addr==LOOP_END[k] and rem[k]!=0 -> rom_addr<=LOOP_START[k], rem[k]<=rem[k]-1; otherwise rom_addr<=rom_addr+1 (wraps mod 2^ROM_AW).
REQ-010 In WAIT with rom_addr==LOOP_END[k] and rem[k]==0: fall through, rem[k]<=LOOP_CNT[k] (re-arm; enables nested loops). Body executes LOOP_CNT[k]+1 times per entry.
REQ-011 Coinciding LOOP_END values: only lowest-index loop with rem!=0 jumps and decrements; loops with equal end and rem==0 re-arm; other matching loops unchanged.
REQ-012 ram_a_addr: src1 in READ_SRC1, src2 in READ_SRC2, else 0.
REQ-013 ram_b_addr: READ_SRC1 op ADD/SUB/CUBIC -> CMD_ADD/CMD_SUB/CMD_CUBIC, MULT -> 0; READ_SRC2 -> src2; WRITE -> dest; else 0.
REQ-014 pe registered next cycle from current state/op: READ_SRC1 ADD/SUB 11001000000, CUBIC 11111000000, MULT 11110000000; READ_SRC2 ADD/SUB 00110000000, CUBIC 0, MULT 00001000000; CALC ADD/SUB 00000010001, CUBIC 01010000001, MULT 00000111111; all other states 0.
REQ-015 pe and done are registered with async reset to 0.

Reset
REQ-016 reset=1 asynchronously forces: state IDLE, rom_addr 0, count 0, pe 0, done 0, rem[k]=LOOP_CNT[k]; busy=0, ram_b_w=0, ram_a_addr=0, ram_b_addr=0.
REQ-017 Reset mid-program (any state) aborts with no further RAM write; new start required after release.

Verification
REQ-018 Reset, start pulse, ROM[0]=ADD dest=5 src1=1 src2=2 times=3, ROM[1] times=0 -> READ_SRC1 two cycles after start, 3 CALC cycles, ram_b_w=1 with ram_b_addr=5 once, done pulse one cycle, busy falls.
REQ-019 NLOOP=1, LOOP_START=2, LOOP_END=3, LOOP_CNT=2 -> addresses 2..3 executed 3 times, then 4; second entry to loop again runs 3 times (re-arm).
REQ-020 Nested loops: loop0 2..3 CNT=1, loop1 1..4 CNT=1 -> inner body 4 times total, outer body 2 times, addresses 2,3 each executed 4 times.
REQ-021 MULT instruction times=1 -> pe sequence 11110000000, 00001000000, 00000111111, then 0; ram_b_addr 0 in READ_SRC1.
REQ-022 Assert reset during CALC -> outputs at reset values same cycle, no ram_b_w; start while busy ignored; restart runs from rom_addr 0.

Source files
------------

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: steps a ROM program through fetch/read/calc/write phases,
// drives RAM port addresses and the PE control vector, with nested hardware loops.
module microcode_sequencer #(
  parameter int unsigned ROM_AW  = 9,
  parameter int unsigned RAM_AW  = 6,
  parameter int unsigned TIMES_W = 9,
  parameter int unsigned NLOOP   = 2,
  parameter int unsigned CNT_W   = 9,
  parameter logic [NLOOP*ROM_AW-1:0] LOOP_START = {9'd288, 9'd21},
  parameter logic [NLOOP*ROM_AW-1:0] LOOP_END   = {9'd301, 9'd116},
  parameter logic [NLOOP*CNT_W-1:0]  LOOP_CNT   = {9'd294, 9'd294},
  parameter logic [RAM_AW-1:0] CMD_ADD   = RAM_AW'(4),
  parameter logic [RAM_AW-1:0] CMD_SUB   = RAM_AW'(8),
  parameter logic [RAM_AW-1:0] CMD_CUBIC = RAM_AW'(16)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  output logic [ROM_AW-1:0]               rom_addr,
  input  logic [3*RAM_AW+2+TIMES_W-1:0]   rom_q,
  output logic [RAM_AW-1:0]               ram_a_addr,
  output logic [RAM_AW-1:0]               ram_b_addr,
  output logic                            ram_b_w,
  output logic [10:0]                     pe,
  output logic                            busy,
  output logic                            done
);

  typedef enum logic [2:0] {
    IDLE, FETCH, READ_SRC1, READ_SRC2, CALC, WAIT, WRITE, DON
  } state_t;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_CUBIC, OP_MULT} op_t;

  state_t              state_q, state_d;
  logic [TIMES_W-1:0]  count;
  logic [CNT_W-1:0]    rem [NLOOP];
  logic [10:0]         pe_d;
  logic [ROM_AW-1:0]   addr_nxt;
  logic [NLOOP-1:0]    jump_sel;
  logic [NLOOP-1:0]    rearm;
  logic                jump_found;

  logic [RAM_AW-1:0]   dest, src1, src2;
  logic [TIMES_W-1:0]  times;
  op_t                 op;

  assign src2  = rom_q[RAM_AW-1:0];
  assign times = rom_q[RAM_AW +: TIMES_W];
  assign op    = op_t'(rom_q[RAM_AW+TIMES_W +: 2]);
  assign src1  = rom_q[RAM_AW+TIMES_W+2 +: RAM_AW];
  assign dest  = rom_q[2*RAM_AW+TIMES_W+2 +: RAM_AW];

  assign busy = (state_q != IDLE);

  // Only the lowest-index active loop jumps; every exhausted loop ending here re-arms.
  always_comb begin
    jump_found = 1'b0;
    jump_sel   = '0;
    rearm      = '0;
    addr_nxt   = rom_addr + ROM_AW'(1);
    for (int unsigned k = 0; k < NLOOP; k++) begin
      if (rom_addr == LOOP_END[k*ROM_AW +: ROM_AW]) begin
        if (rem[k] == '0) begin
          rearm[k] = 1'b1;
        end else if (!jump_found) begin
          jump_found  = 1'b1;
          jump_sel[k] = 1'b1;
          addr_nxt    = LOOP_START[k*ROM_AW +: ROM_AW];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ram_a_addr = '0;
    ram_b_addr = '0;
    ram_b_w    = 1'b0;
    pe_d       = '0;
    case (state_q)
      IDLE:  if (start) state_d = FETCH;
      FETCH: state_d = READ_SRC1;
      READ_SRC1: begin
        state_d    = READ_SRC2;
        ram_a_addr = src1;
        case (op)
          OP_ADD:   begin ram_b_addr = CMD_ADD;   pe_d = 11'b11001000000; end
          OP_SUB:   begin ram_b_addr = CMD_SUB;   pe_d = 11'b11001000000; end
          OP_CUBIC: begin ram_b_addr = CMD_CUBIC; pe_d = 11'b11111000000; end
          default:  begin ram_b_addr = '0;        pe_d = 11'b11110000000; end
        endcase
      end
      READ_SRC2: begin
        state_d    = (times == '0) ? DON : CALC;
        ram_a_addr = src2;
        ram_b_addr = src2;
        case (op)
          OP_ADD, OP_SUB: pe_d = 11'b00110000000;
          OP_CUBIC:       pe_d = '0;
          default:        pe_d = 11'b00001000000;
        endcase
      end
      CALC: begin
        if (count == TIMES_W'(1)) state_d = WAIT;
        case (op)
          OP_ADD, OP_SUB: pe_d = 11'b00000010001;
          OP_CUBIC:       pe_d = 11'b01010000001;
          default:        pe_d = 11'b00000111111;
        endcase
      end
      WAIT: state_d = WRITE;
      WRITE: begin
        state_d    = READ_SRC1;
        ram_b_addr = dest;
        ram_b_w    = 1'b1;
      end
      DON:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_addr <= '0;
      count    <= '0;
      pe       <= '0;
      done     <= 1'b0;
      for (int unsigned k = 0; k < NLOOP; k++) rem[k] <= LOOP_CNT[k*CNT_W +: CNT_W];
    end else begin
      pe   <= pe_d;
      done <= (state_q == DON);
      case (state_q)
        READ_SRC1: count <= times;
        CALC:      count <= count - TIMES_W'(1);
        WAIT: begin
          rom_addr <= addr_nxt;
          for (int unsigned k = 0; k < NLOOP; k++) begin
            if (jump_sel[k])   rem[k] <= rem[k] - CNT_W'(1);
            else if (rearm[k]) rem[k] <= LOOP_CNT[k*CNT_W +: CNT_W];
          end
        end
        DON: begin
          rom_addr <= '0;
          for (int unsigned k = 0; k < NLOOP; k++) rem[k] <= LOOP_CNT[k*CNT_W +: CNT_W];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Scoreboard bench for microcode_sequencer: two instances (single loop, nested loops),
// expected RAM write addresses queued at launch and popped on each write strobe.
module tb_microcode_sequencer;

  localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MULT = 2'd3;
  localparam logic [10:0] PE_ADDCALC = 11'b00000010001;
  localparam logic [10:0] PE_MULCALC = 11'b00000111111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;

  logic [8:0]  rom_addr_a, rom_addr_b;
  logic [28:0] rom_q_a = '0, rom_q_b = '0;
  logic [5:0]  ram_a_addr_a, ram_b_addr_a, ram_a_addr_b, ram_b_addr_b;
  logic        ram_b_w_a, ram_b_w_b, busy_a, busy_b, done_a, done_b;
  logic [10:0] pe_a, pe_b;

  logic [28:0] rom_a [512];
  logic [28:0] rom_b [512];

  int total = 0;
  int bad   = 0;
  int qa[$];
  int qb[$];

  bit sel = 1'b0;
  logic        done_s, busy_s;
  logic [10:0] pe_s;
  assign done_s = sel ? done_b : done_a;
  assign busy_s = sel ? busy_b : busy_a;
  assign pe_s   = sel ? pe_b   : pe_a;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_q_a <= rom_a[rom_addr_a];
    rom_q_b <= rom_b[rom_addr_b];
  end

  microcode_sequencer #(
    .NLOOP(1), .LOOP_START(9'd2), .LOOP_END(9'd3), .LOOP_CNT(9'd2)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .rom_addr(rom_addr_a), .rom_q(rom_q_a),
    .ram_a_addr(ram_a_addr_a), .ram_b_addr(ram_b_addr_a), .ram_b_w(ram_b_w_a),
    .pe(pe_a), .busy(busy_a), .done(done_a)
  );

  microcode_sequencer #(
    .NLOOP(2), .LOOP_START({9'd1, 9'd2}), .LOOP_END({9'd4, 9'd3}), .LOOP_CNT({9'd1, 9'd1})
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .rom_addr(rom_addr_b), .rom_q(rom_q_b),
    .ram_a_addr(ram_a_addr_b), .ram_b_addr(ram_b_addr_b), .ram_b_w(ram_b_w_b),
    .pe(pe_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [28:0] ins(input logic [5:0] d, input logic [5:0] s1,
                                      input logic [1:0] op, input logic [8:0] t,
                                      input logic [5:0] s2);
    return {d, s1, op, t, s2};
  endfunction

  always @(negedge clk) begin
    if (ram_b_w_a) begin
      if (qa.size() == 0) chk("a_unexpected_write", ram_b_w_a, 1'b0);
      else                chk("a_write_addr", ram_b_addr_a, qa.pop_front());
    end
    if (ram_b_w_b) begin
      if (qb.size() == 0) chk("b_unexpected_write", ram_b_w_b, 1'b0);
      else                chk("b_write_addr", ram_b_addr_b, qb.pop_front());
    end
  end

  task automatic pulse_start(input bit s);
    @(negedge clk);
    if (s) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic run_to_done(input bit s, input string tag, input logic [10:0] calc_pe,
                             input int exp_calc);
    int n_calc = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (pe_s == calc_pe) n_calc++;
      if (done_s) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, seen, 1'b1);
    if (seen) begin
      chk({tag, "_busy_at_done"}, busy_s, 1'b0);
      chk({tag, "_calc_cycles"}, n_calc, exp_calc);
      @(negedge clk);
      chk({tag, "_done_width"}, done_s, 1'b0);
    end
    chk({tag, "_queue_empty"}, s ? qb.size() : qa.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      rom_a[i] = '0;
      rom_b[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_busy", {busy_b, busy_a}, 2'b00);
    chk("rst_done", {done_b, done_a}, 2'b00);
    chk("rst_pe", {pe_b, pe_a}, 22'd0);
    chk("rst_rom_addr", {rom_addr_b, rom_addr_a}, 18'd0);
    chk("rst_ram_b_w", {ram_b_w_b, ram_b_w_a}, 2'b00);
    chk("rst_ram_addrs", {ram_a_addr_a, ram_b_addr_a, ram_a_addr_b, ram_b_addr_b}, 24'd0);
    reset = 1'b0;

    // Basic ADD, times=3, then terminator; a start pulse while busy must be ignored
    sel = 1'b0;
    rom_a[0] = ins(6'd5, 6'd1, OP_ADD, 9'd3, 6'd2);
    rom_a[1] = ins(6'd0, 6'd0, OP_ADD, 9'd0, 6'd0);
    qa.push_back(5);
    pulse_start(1'b0);
    chk("add_fetch_busy", busy_a, 1'b1);
    chk("add_fetch_addr", rom_addr_a, 9'd0);
    @(negedge clk);
    chk("add_rs1_a_addr", ram_a_addr_a, 6'd1);
    chk("add_rs1_b_addr", ram_b_addr_a, 6'd4);
    chk("add_rs1_w", ram_b_w_a, 1'b0);
    @(negedge clk);
    chk("add_rs2_pe", pe_a, 11'b11001000000);
    chk("add_rs2_a_addr", ram_a_addr_a, 6'd2);
    chk("add_rs2_b_addr", ram_b_addr_a, 6'd2);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("add_calc1_pe", pe_a, 11'b00110000000);
    run_to_done(1'b0, "add", PE_ADDCALC, 3);
    repeat (3) @(negedge clk);
    chk("add_stays_idle", busy_a, 1'b0);

    // MULT times=1: PE control sequence and zero constant address
    rom_a[0] = ins(6'd7, 6'd3, OP_MULT, 9'd1, 6'd4);
    qa.push_back(7);
    pulse_start(1'b0);
    @(negedge clk);
    chk("mul_rs1_b_addr", ram_b_addr_a, 6'd0);
    chk("mul_rs1_a_addr", ram_a_addr_a, 6'd3);
    @(negedge clk);
    chk("mul_pe0", pe_a, 11'b11110000000);
    @(negedge clk);
    chk("mul_pe1", pe_a, 11'b00001000000);
    @(negedge clk);
    chk("mul_pe2", pe_a, 11'b00000111111);
    @(negedge clk);
    chk("mul_pe3", pe_a, 11'd0);
    run_to_done(1'b0, "mul", PE_MULCALC, 0);

    // Reset asserted mid-CALC aborts without a write; restart begins at address 0
    rom_a[0] = ins(6'd9, 6'd1, OP_SUB, 9'd5, 6'd2);
    pulse_start(1'b0);
    @(negedge clk);
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", busy_a, 1'b0);
    chk("abort_pe", pe_a, 11'd0);
    chk("abort_w", ram_b_w_a, 1'b0);
    chk("abort_rom_addr", rom_addr_a, 9'd0);
    chk("abort_b_addr", ram_b_addr_a, 6'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_no_autostart", busy_a, 1'b0);
    rom_a[0] = ins(6'd9, 6'd1, OP_SUB, 9'd1, 6'd2);
    qa.push_back(9);
    pulse_start(1'b0);
    chk("restart_addr", rom_addr_a, 9'd0);
    run_to_done(1'b0, "restart", PE_ADDCALC, 1);

    // Single loop 2..3, count 2: body runs three times, then falls through
    for (int i = 0; i < 5; i++) rom_a[i] = ins(6'(i), 6'd0, OP_ADD, 9'd1, 6'd0);
    rom_a[5] = '0;
    for (int r = 0; r < 2; r++) begin
      foreach (qa[j]) qa.delete(j);
      qa = '{0, 1, 2, 3, 2, 3, 2, 3, 4};
      pulse_start(1'b0);
      run_to_done(1'b0, r == 0 ? "loop1" : "loop1_again", PE_ADDCALC, 9);
    end

    // Nested loops: inner 2..3 count 1, outer 1..4 count 1
    sel = 1'b1;
    for (int i = 0; i < 6; i++) rom_b[i] = ins(6'(i), 6'd0, OP_ADD, 9'd1, 6'd0);
    rom_b[6] = '0;
    for (int r = 0; r < 2; r++) begin
      qb = '{0, 1, 2, 3, 2, 3, 4, 1, 2, 3, 2, 3, 4, 5};
      pulse_start(1'b1);
      run_to_done(1'b1, r == 0 ? "nest" : "nest_again", PE_ADDCALC, 14);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
